prio_encoder_rr: RTL and testbench
==================================

Name: prio_encoder_rr

Overview:
- Parametrised, registered N-to-log2(N) encoder with valid/ready handshake on both sides.
- Generalises the 4-to-2 gate-level encoder in three ways:
  - any power-of-two width;
  - a defined priority for multi-hot inputs, either fixed or round-robin;
  - explicit zero-input and multi-hot flags.
- Sits between request sources (interrupt lines, channel requests) and a downstream consumer that may stall.

Parameters:
- N, 8, number of request inputs; power of two, 2..64.
- W, $clog2(N), index width; derived, not overridden.
- MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin (rotating priority).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  req is valid this cycle
- in_ready  output  1  block can accept req this cycle
- req  input  N  request vector, any number of bits set
- out_valid  output  1  encoded result held in output register
- out_ready  input  1  consumer takes result this cycle
- out_idx  output  W  encoded index of winning request
- out_any  output  1  at least one req bit was set
- out_multi  output  1  two or more req bits were set

Behaviour:
- Reset (asynchronous, immediate on rst=1): out_valid=0, out_idx=0, out_any=0, out_multi=0, last_idx=0.
  - in_ready is combinational and reads 1 during reset.
  - Reset mid-transfer drops any held result without completing it.
- Handshake:
  - in_ready = !out_valid || out_ready (single-stage pipe, full throughput, combinational ready path).
  - Accept occurs when in_valid && in_ready; the result is registered on that clock edge.
  - Latency: out_valid rises one cycle after accept.
  - out_valid=1 && out_ready=0: out_idx, out_any and out_multi hold stable. No new accept that cycle.
  - out_ready=1 with a simultaneous accept: old result retires and the new one loads on the same edge, so out_valid stays 1.
  - out_ready=1 with no accept: out_valid clears next edge.
- Internal FSM, two states:
  - EMPTY (out_valid=0): accept → FULL.
  - FULL: out_ready && !accept → EMPTY; otherwise stay.
- Encoding, MODE 0: out_idx = highest set bit of req (d[N-1] has top priority, matching the 4-to-2 convention).
- Encoding, MODE 1:
  - Search order starts at (last_idx-1) mod N and descends with wrap-around through last_idx.
  - out_idx is the first set bit in that order.
  - last_idx updates to out_idx on every accept with out_any=1.
  - After reset, last_idx=0, so the first search order is N-1..0, identical to MODE 0.
  - A single requester that stays asserted wins repeatedly.
- Zero request:
  - Accept with req=0 gives out_valid=1, out_any=0, out_idx=0, out_multi=0.
  - last_idx is unchanged. The result is still delivered and must be consumed.
- out_multi = 1 iff popcount(req) >= 2 at accept.
- No X propagation:
  - req is sampled only on accept.
  - Outputs are registered, except in_ready.

Test Plan:
- Reset: assert rst mid-stall with out_valid=1 and out_idx=5 → outputs clear asynchronously to 0 and in_ready=1. Deassert rst, accept req=8'h01 → out_idx=0, out_any=1, out_multi=0.
- One-hot sweep, N=8, MODE 0, out_ready=1: req=8'h80,8'h04,8'h01 back-to-back → out_idx=7,2,0 on consecutive cycles, out_valid held 1 throughout, out_multi=0.
- Multi-hot fixed priority, MODE 0: req=8'h5A → out_idx=6, out_any=1, out_multi=1. Then req=8'h00 → out_any=0, out_idx=0, out_multi=0.
- Round-robin, MODE 1: req=8'h81 applied four times → out_idx=7,0,7,0. Then req=8'h10 → out_idx=4, and last_idx=4 afterwards.
- Backpressure: out_ready=0 for 3 cycles after accepting req=8'h20 → out_idx=5 stable, in_ready=0, new req ignored. out_ready=1 with in_valid=1 and req=8'h02 → out_idx=1 on next edge, out_valid never drops.
- Parameter sweep: N=4 with MODE 0, req=4'b1000,4'b0100,4'b0010,4'b0001 → out_idx=3,2,1,0, matching the 4-to-2 truth table. N=64 with MODE 1, req bit 63 and bit 0 set → alternates 63,0.

Source files
------------

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with valid/ready handshake on both sides.
// MODE 0 picks the highest set request. MODE 1 rotates priority, starting just below the
// last winner. A single output register gives full throughput with a combinational ready path.
module prio_encoder_rr #(
  parameter int unsigned N    = 8,
  parameter int unsigned MODE = 0,
  localparam int unsigned W   = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_any,
  output logic         out_multi
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e         state_q;
  logic [W-1:0]   last_idx_q;

  logic           accept;
  logic [W-1:0]   fix_idx;
  logic [W-1:0]   rr_idx;
  logic [W-1:0]   rr_cand;
  logic           rr_found;
  logic [W-1:0]   enc_idx;
  logic           enc_any;
  logic           enc_multi;

  assign out_valid = (state_q == StFull);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // Fixed priority: scan upwards so the highest set bit is the last one to overwrite.
  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fix_idx = W'(i);
    end
  end

  // Round-robin: scan downwards from last_idx-1, wrapping through last_idx itself.
  // Index arithmetic wraps for free because N is a power of two.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int k = 0; k < N; k++) begin
      rr_cand = last_idx_q - W'(k + 1);
      if (!rr_found && req[rr_cand]) begin
        rr_idx   = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  // Select the encoding and derive the zero / multi-hot flags.
  always_comb begin
    enc_idx   = (MODE == 1) ? rr_idx : fix_idx;
    enc_any   = |req;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    enc_multi = |(req & (req - N'(1)));
  end

  // Handshake FSM plus the result register; req is only looked at on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      out_idx    <= '0;
      out_any    <= 1'b0;
      out_multi  <= 1'b0;
      last_idx_q <= '0;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_q <= StFull;
        StFull:  if (out_ready && !accept) state_q <= StEmpty;
        default: state_q <= StEmpty;
      endcase
      if (accept) begin
        out_idx   <= enc_any ? enc_idx : '0;
        out_any   <= enc_any;
        out_multi <= enc_multi;
        // A zero request must not disturb the rotation point.
        if (enc_any) last_idx_q <= enc_idx;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed test for prio_encoder_rr: four instances (N=8 fixed, N=8 round-robin,
// N=4 fixed, N=64 round-robin) share clock, reset and handshake controls.
module tb_prio_encoder_rr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0]  req8 = '0;
  logic [3:0]  req4 = '0;
  logic [63:0] req64 = '0;

  logic       rdy_f8, vld_f8, any_f8, mul_f8;
  logic [2:0] idx_f8;
  logic       rdy_r8, vld_r8, any_r8, mul_r8;
  logic [2:0] idx_r8;
  logic       rdy_f4, vld_f4, any_f4, mul_f4;
  logic [1:0] idx_f4;
  logic       rdy_r64, vld_r64, any_r64, mul_r64;
  logic [5:0] idx_r64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(8), .MODE(0)) u_f8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_f8), .req(req8),
    .out_valid(vld_f8), .out_ready(out_ready), .out_idx(idx_f8), .out_any(any_f8),
    .out_multi(mul_f8)
  );

  prio_encoder_rr #(.N(8), .MODE(1)) u_r8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_r8), .req(req8),
    .out_valid(vld_r8), .out_ready(out_ready), .out_idx(idx_r8), .out_any(any_r8),
    .out_multi(mul_r8)
  );

  prio_encoder_rr #(.N(4), .MODE(0)) u_f4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_f4), .req(req4),
    .out_valid(vld_f4), .out_ready(out_ready), .out_idx(idx_f4), .out_any(any_f4),
    .out_multi(mul_f4)
  );

  prio_encoder_rr #(.N(64), .MODE(1)) u_r64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_r64), .req(req64),
    .out_valid(vld_r64), .out_ready(out_ready), .out_idx(idx_r64), .out_any(any_r64),
    .out_multi(mul_r64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    check("rst_valid", 64'(vld_f8), 64'd0);
    check("rst_idx", 64'(idx_f8), 64'd0);
    check("rst_any", 64'(any_f8), 64'd0);
    check("rst_multi", 64'(mul_f8), 64'd0);
    check("rst_in_ready", 64'(rdy_f8), 64'd1);
    rst = 1'b0;

    // Load idx 5 and stall, then reset asynchronously mid-cycle.
    in_valid = 1'b1; req8 = 8'h20;
    tick();
    in_valid = 1'b0;
    check("stall_valid", 64'(vld_f8), 64'd1);
    check("stall_idx", 64'(idx_f8), 64'd5);
    check("stall_in_ready", 64'(rdy_f8), 64'd0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(vld_f8), 64'd0);
    check("async_rst_idx", 64'(idx_f8), 64'd0);
    check("async_rst_in_ready", 64'(rdy_f8), 64'd1);
    #2 rst = 1'b0;
    tick();
    in_valid = 1'b1; req8 = 8'h01;
    tick();
    in_valid = 1'b0;
    check("post_rst_idx", 64'(idx_f8), 64'd0);
    check("post_rst_any", 64'(any_f8), 64'd1);
    check("post_rst_multi", 64'(mul_f8), 64'd0);
    check("post_rst_valid", 64'(vld_f8), 64'd1);

    // One-hot sweep at full throughput.
    out_ready = 1'b1;
    in_valid = 1'b1; req8 = 8'h80;
    tick();
    check("sweep_idx7", 64'(idx_f8), 64'd7);
    check("sweep_valid0", 64'(vld_f8), 64'd1);
    req8 = 8'h04;
    tick();
    check("sweep_idx2", 64'(idx_f8), 64'd2);
    check("sweep_valid1", 64'(vld_f8), 64'd1);
    check("sweep_multi1", 64'(mul_f8), 64'd0);
    req8 = 8'h01;
    tick();
    check("sweep_idx0", 64'(idx_f8), 64'd0);
    check("sweep_valid2", 64'(vld_f8), 64'd1);
    in_valid = 1'b0;
    tick();
    check("sweep_drain", 64'(vld_f8), 64'd0);

    // Multi-hot fixed priority, then an all-zero request.
    in_valid = 1'b1; req8 = 8'h5A;
    tick();
    check("multi_idx", 64'(idx_f8), 64'd6);
    check("multi_any", 64'(any_f8), 64'd1);
    check("multi_multi", 64'(mul_f8), 64'd1);
    req8 = 8'h00;
    tick();
    check("zero_valid", 64'(vld_f8), 64'd1);
    check("zero_any", 64'(any_f8), 64'd0);
    check("zero_idx", 64'(idx_f8), 64'd0);
    check("zero_multi", 64'(mul_f8), 64'd0);
    in_valid = 1'b0;
    tick();

    // Round-robin from a fresh reset; N=4 fixed sweep and N=64 rotation ride along.
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req8  = 8'h81;
      req4  = 4'b1000 >> i;
      req64 = {1'b1, 62'd0, 1'b1};
      tick();
      check($sformatf("rr8_step%0d", i), 64'(idx_r8), (i % 2 == 0) ? 64'd7 : 64'd0);
      check($sformatf("f4_step%0d", i), 64'(idx_f4), 64'(3 - i));
      check($sformatf("rr64_step%0d", i), 64'(idx_r64), (i % 2 == 0) ? 64'd63 : 64'd0);
    end
    req4 = '0; req64 = '0;
    req8 = 8'h10;
    tick();
    check("rr8_single4", 64'(idx_r8), 64'd4);
    // With last_idx=4 the order is 3..0,7,6,5,4 so bit 5 beats bit 4.
    req8 = 8'h30;
    tick();
    check("rr8_after4", 64'(idx_r8), 64'd5);
    req8 = 8'h00;
    tick();
    check("rr8_zero_any", 64'(any_r8), 64'd0);
    // last_idx still 5: order 4..0 first, so bit 0 beats bit 5.
    req8 = 8'h21;
    tick();
    check("rr8_zero_keeps_last", 64'(idx_r8), 64'd0);
    in_valid = 1'b0;
    tick();
    check("rr8_drain", 64'(vld_r8), 64'd0);

    // Backpressure: result held, new requests ignored, then back-to-back retire/load.
    out_ready = 1'b0;
    in_valid = 1'b1; req8 = 8'h20;
    tick();
    check("bp_load_idx", 64'(idx_f8), 64'd5);
    req8 = 8'h02;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_in_ready%0d", i), 64'(rdy_f8), 64'd0);
      tick();
      check($sformatf("bp_hold_idx%0d", i), 64'(idx_f8), 64'd5);
      check($sformatf("bp_hold_valid%0d", i), 64'(vld_f8), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(rdy_f8), 64'd1);
    tick();
    check("bp_new_idx", 64'(idx_f8), 64'd1);
    check("bp_new_valid", 64'(vld_f8), 64'd1);
    in_valid = 1'b0;
    tick();
    check("bp_drain", 64'(vld_f8), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
